// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write bypass and RAW scoreboard; wr_*/iss_* writeback and issue ports, rd_* combinational reads with busy, wr_conflict/conflict_cnt report same-address multi-writes
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 4,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        iss_en,
  input  logic [NUM_WR*ADDR_W-1:0] iss_addr,
  input  logic                     sb_flush,
  output logic                     wr_conflict,
  output logic [CNT_W-1:0]         conflict_cnt
);
  localparam int NREG = 2**ADDR_W;
  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy, busy_nxt;
  logic              conflict, hit;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] val;
  always_comb begin
    conflict = 1'b0;
    for (int j = 0; j < NUM_WR; j++)
      for (int k = j + 1; k < NUM_WR; k++)
        if (wr_en[j] && wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] != '0 &&
            wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W])
          conflict = 1'b1;
  end
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NUM_WR; k++)
      if (wr_en[k]) busy_nxt[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
    for (int k = 0; k < NUM_WR; k++)
      if (iss_en[k]) busy_nxt[iss_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
    busy_nxt[0] = 1'b0;
    busy_nxt = sb_flush ? '0 : busy_nxt;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
      busy         <= '0;
      wr_conflict  <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++)
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] != '0)
          mem[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
      busy        <= busy_nxt;
      wr_conflict <= conflict;
      if (conflict && conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    hit     = 1'b0;
    val     = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra  = rd_addr[i*ADDR_W +: ADDR_W];
      hit = 1'b0;
      val = mem[ra];
      for (int k = 0; k < NUM_WR; k++)
        if (BYPASS != 0 && wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == ra) begin
          hit = 1'b1;
          val = wr_data[k*DATA_W +: DATA_W];
        end
      if (resetn && rd_en[i] && ra != '0) begin
        rd_data[i*DATA_W +: DATA_W] = val;
        rd_busy[i] = busy[ra] & ~hit;
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed self-checking bench for regfile_mp_sb (BYPASS=1)
module tb_regfile_mp_sb;
  localparam int DW = 32, AW = 5, NW = 2, NR = 4, CW = 16;
  logic clk = 1'b0, resetn = 1'b0, sb_flush;
  logic [NW-1:0] wr_en, iss_en;
  logic [NW*AW-1:0] wr_addr, iss_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR-1:0] rd_en, rd_busy;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic wr_conflict;
  logic [CW-1:0] conflict_cnt;
  int checks = 0, failures = 0;

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_WR(NW), .NUM_RD(NR), .BYPASS(1), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .sb_flush(sb_flush),
    .wr_conflict(wr_conflict), .conflict_cnt(conflict_cnt));

  always #5 clk = ~clk;

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
    iss_en = '0; iss_addr = '0; sb_flush = 1'b0;
  endtask
  task automatic wr(input int k, input int a, input logic [DW-1:0] d);
    wr_en[k] = 1'b1; wr_addr[k*AW +: AW] = AW'(a); wr_data[k*DW +: DW] = d;
  endtask
  task automatic rd(input int i, input int a);
    rd_en[i] = 1'b1; rd_addr[i*AW +: AW] = AW'(a);
  endtask
  task automatic iss(input int k, input int a);
    iss_en[k] = 1'b1; iss_addr[k*AW +: AW] = AW'(a);
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); resetn = 1'b0;
    tick(); tick();
    rd(0, 3); #1;
    checks++; if (rd_data[0 +: DW] !== '0) begin failures++; $display("FAIL reset_rd_low got=%h exp=0", rd_data[0 +: DW]); end
    resetn = 1'b1; idle();
    for (int r = 1; r < 32; r++) begin
      for (int i = 0; i < NR; i++) rd(i, r);
      #1;
      checks++; if (rd_data !== '0 || rd_busy !== '0) begin failures++; $display("FAIL reset_read r%0d got=%h busy=%b exp=0", r, rd_data, rd_busy); end
    end
    checks++; if (conflict_cnt !== 16'd0 || wr_conflict !== 1'b0) begin failures++; $display("FAIL reset_cnt got=%0d/%b exp=0/0", conflict_cnt, wr_conflict); end
  endtask

  task automatic test_parallel();
    idle(); wr(0, 3, 32'h11111111); wr(1, 4, 32'h22222222); tick();
    idle(); rd(0, 3); rd(1, 4); #1;
    checks++; if (rd_data[0 +: DW] !== 32'h11111111) begin failures++; $display("FAIL par_r3 got=%h exp=11111111", rd_data[0 +: DW]); end
    checks++; if (rd_data[DW +: DW] !== 32'h22222222) begin failures++; $display("FAIL par_r4 got=%h exp=22222222", rd_data[DW +: DW]); end
    checks++; if (wr_conflict !== 1'b0) begin failures++; $display("FAIL par_conflict got=%b exp=0", wr_conflict); end
  endtask

  task automatic test_conflict();
    idle(); wr(0, 5, 32'hAAAA0000); wr(1, 5, 32'h5555FFFF); tick();
    idle(); rd(3, 5); #1;
    checks++; if (rd_data[3*DW +: DW] !== 32'h5555FFFF) begin failures++; $display("FAIL conf_r5 got=%h exp=5555ffff", rd_data[3*DW +: DW]); end
    checks++; if (wr_conflict !== 1'b1) begin failures++; $display("FAIL conf_pulse got=%b exp=1", wr_conflict); end
    checks++; if (conflict_cnt !== 16'd1) begin failures++; $display("FAIL conf_cnt1 got=%0d exp=1", conflict_cnt); end
    tick();
    checks++; if (wr_conflict !== 1'b0) begin failures++; $display("FAIL conf_pulse_end got=%b exp=0", wr_conflict); end
    for (int n = 0; n < 3; n++) begin
      idle(); wr(0, 6, 32'h1); wr(1, 6, 32'h2); tick();
    end
    idle();
    checks++; if (conflict_cnt !== 16'd4 || wr_conflict !== 1'b1) begin failures++; $display("FAIL conf_cnt4 got=%0d/%b exp=4/1", conflict_cnt, wr_conflict); end
    tick();
    wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'hEEEEEEEE); tick();
    idle(); rd(0, 0); #1;
    checks++; if (wr_conflict !== 1'b0 || conflict_cnt !== 16'd4) begin failures++; $display("FAIL conf_r0 got=%b/%0d exp=0/4", wr_conflict, conflict_cnt); end
    checks++; if (rd_data[0 +: DW] !== '0) begin failures++; $display("FAIL r0_zero got=%h exp=0", rd_data[0 +: DW]); end
  endtask

  task automatic test_bypass();
    idle(); wr(0, 7, 32'hDEADBEEF); rd(2, 7); #1;
    checks++; if (rd_data[2*DW +: DW] !== 32'hDEADBEEF) begin failures++; $display("FAIL byp_single got=%h exp=deadbeef", rd_data[2*DW +: DW]); end
    wr(1, 7, 32'h12345678); #1;
    checks++; if (rd_data[2*DW +: DW] !== 32'h12345678) begin failures++; $display("FAIL byp_prio got=%h exp=12345678", rd_data[2*DW +: DW]); end
    rd_en[2] = 1'b0; #1;
    checks++; if (rd_data[2*DW +: DW] !== '0) begin failures++; $display("FAIL byp_rden0 got=%h exp=0", rd_data[2*DW +: DW]); end
    tick();
    idle(); rd(2, 7); #1;
    checks++; if (rd_data[2*DW +: DW] !== 32'h12345678) begin failures++; $display("FAIL byp_commit got=%h exp=12345678", rd_data[2*DW +: DW]); end
  endtask

  task automatic test_scoreboard();
    idle(); iss(0, 9); tick();
    idle(); rd(1, 9); #1;
    checks++; if (rd_busy[1] !== 1'b1) begin failures++; $display("FAIL sb_issue got=%b exp=1", rd_busy[1]); end
    wr(0, 9, 32'h99); iss(1, 9); #1;
    checks++; if (rd_busy[1] !== 1'b0) begin failures++; $display("FAIL sb_mask got=%b exp=0", rd_busy[1]); end
    tick();
    idle(); rd(1, 9); #1;
    checks++; if (rd_busy[1] !== 1'b1) begin failures++; $display("FAIL sb_reissue got=%b exp=1", rd_busy[1]); end
    wr(0, 9, 32'h9A); #1;
    checks++; if (rd_busy[1] !== 1'b0 || rd_data[DW +: DW] !== 32'h9A) begin failures++; $display("FAIL sb_wb_same got=%b/%h exp=0/9a", rd_busy[1], rd_data[DW +: DW]); end
    tick();
    idle(); rd(1, 9); iss(0, 0); #1;
    checks++; if (rd_busy[1] !== 1'b0 || rd_data[DW +: DW] !== 32'h9A) begin failures++; $display("FAIL sb_wb got=%b/%h exp=0/9a", rd_busy[1], rd_data[DW +: DW]); end
    tick();
    idle(); rd(0, 0); #1;
    checks++; if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL sb_r0 got=%b exp=0", rd_busy[0]); end
  endtask

  task automatic test_flush();
    idle(); iss(0, 1); iss(1, 2); tick();
    idle(); rd(0, 1); rd(1, 2); #1;
    checks++; if (rd_busy[1:0] !== 2'b11) begin failures++; $display("FAIL fl_set got=%b exp=11", rd_busy[1:0]); end
    sb_flush = 1'b1; iss(0, 3); tick();
    idle(); rd(0, 1); rd(1, 2); rd(2, 3); #1;
    checks++; if (rd_busy[2:0] !== 3'b000) begin failures++; $display("FAIL fl_clear got=%b exp=000", rd_busy[2:0]); end
  endtask

  task automatic test_midop_reset();
    idle(); iss(0, 10); tick();
    idle(); resetn = 1'b0; wr(0, 3, 32'hFFFF); wr(1, 11, 32'hBEEF); iss(0, 12); rd(0, 3); rd(1, 10); #1;
    checks++; if (rd_data[0 +: DW] !== '0 || rd_busy[1] !== 1'b0) begin failures++; $display("FAIL rst_low_out got=%h/%b exp=0/0", rd_data[0 +: DW], rd_busy[1]); end
    tick();
    resetn = 1'b1; idle(); rd(0, 3); rd(1, 11); rd(2, 10); rd(3, 12); #1;
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL rst_regs got=%h exp=0", rd_data); end
    checks++; if (rd_busy !== '0) begin failures++; $display("FAIL rst_busy got=%b exp=0", rd_busy); end
    checks++; if (conflict_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", conflict_cnt); end
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_conflict();
    test_bypass();
    test_scoreboard();
    test_flush();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port general-purpose register file with an integrated scoreboard, replacing the fixed two-write/four-read register file in the dual-issue core. It supports NUM_WR writeback ports and NUM_RD read ports, with deterministic same-address write priority and optional write-to-read bypass. Per-register busy bits track in-flight producers so the issue stage can stall on RAW hazards. It sits between decode/issue (reads, issue marks) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; register count is 2**ADDR_W
NUM_WR, 2, number of write (writeback) ports and issue-mark ports; port NUM_WR-1 is youngest in program order
NUM_RD, 4, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return array contents only
CNT_W, 16, width of conflict counter

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  synchronous reset, active low
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_W  packed write addresses, port k at [k*ADDR_W +: ADDR_W]
wr_data  in  NUM_WR*DATA_W  packed write data
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  packed read addresses
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_busy  out  NUM_RD  register pending a writeback, combinational
iss_en  in  NUM_WR  per-slot issue mark enable
iss_addr  in  NUM_WR*ADDR_W  destination register of issued instruction
sb_flush  in  1  clear all busy bits (pipeline flush)
wr_conflict  out  1  registered pulse: previous cycle had >=2 enabled writes to the same nonzero address
conflict_cnt  out  CNT_W  saturating count of conflict cycles

Behaviour:
- Register 0 is hardwired zero: never written, never busy, always reads 0.
- Reset (resetn low at a rising edge): all registers 0, all busy bits 0, wr_conflict 0, conflict_cnt 0. Writes, issue marks and flush in that cycle are discarded. While resetn is low, rd_data and rd_busy are driven 0.
- Write: at rising edge, each port with wr_en=1 and wr_addr!=0 writes. If several enabled ports share an address, the highest-index port wins; lower-index writes to that address are dropped. Writes to distinct addresses all commit in the same cycle.
- Conflict: any same-address nonzero multi-write sets wr_conflict=1 for exactly the following cycle. conflict_cnt increments by 1 per conflict cycle regardless of how many ports collide, and saturates at 2**CNT_W-1.
- Read, per port i: rd_en=0 or rd_addr=0 gives 0. With BYPASS=1, if any enabled write port matches rd_addr (nonzero), return wr_data of the highest-index matching port. Otherwise return the array value. With BYPASS=0, always return the array value (pre-edge contents). Every read port sees every write port; there is no per-slot restriction.
- Scoreboard busy[r] next-state, evaluated in this priority order:
  - sb_flush=1: all busy bits 0, overriding same-cycle issue marks and writebacks.
  - Otherwise, iss_en[k] with iss_addr!=0 sets busy[iss_addr].
  - Otherwise, a write to r clears busy[r].
  - If a register is both issued and written back in the same cycle, set wins (new producer outstanding).
- rd_busy[i] = busy[rd_addr] when rd_en=1 and rd_addr!=0. It is masked to 0 when BYPASS=1 and an enabled write to rd_addr occurs this cycle, because the data is being forwarded. Otherwise rd_busy is 0.
- No read latency (combinational). Write, busy and counter latency is 1 cycle.

Test Plan:
- Reset then read: hold resetn low 2 cycles, release; read r1..r31 on all ports -> all rd_data=0, rd_busy=0, conflict_cnt=0.
- Parallel writes: port0 writes r3=0x11111111, port1 writes r4=0x22222222 in one cycle -> next cycle r3/r4 read back those values; wr_conflict stays 0.
- Same-address conflict: port0 r5=0xAAAA0000 and port1 r5=0x5555FFFF in one cycle -> r5=0x5555FFFF; wr_conflict=1 for one cycle; conflict_cnt=1. Repeat 3 cycles -> conflict_cnt=4. Write to r0 on both ports -> no conflict, r0 reads 0.
- Bypass: BYPASS=1, port0 writes r7=0xDEADBEEF while rd_addr[2]=7 -> same-cycle rd_data[2]=0xDEADBEEF. BYPASS=0 build -> old value, new value next cycle.
- Scoreboard: issue r9 -> next cycle rd_busy=1 on r9. Writeback r9 with a concurrent reissue of r9 -> busy remains 1. Writeback alone -> busy 0; same-cycle read shows rd_busy=0 under BYPASS=1.
- Flush and mid-op reset: set busy on r1,r2, assert sb_flush with iss r3 -> all busy 0 including r3. Drive writes with resetn low -> writes discarded, registers 0.
